// File: rtl/fft_frame_sequencer.sv
// Feeds fixed-length sample frames into an FFT, limiting frames in flight and tracking drain beats.
// Optional macro FFT_SEQ_STATS_EN adds frames_fed / frames_drained counters.
module fft_frame_sequencer #(
  parameter int FRAME_LEN     = 128,
  parameter int OUT_PER_FRAME = 128,
  parameter int MAX_INFLIGHT  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        src_valid,
  output logic        src_ready,
  input  logic [16:0] src_re,
  input  logic [16:0] src_im,
  output logic        push_in,
  output logic        First_Data,
  output logic [16:0] DinR,
  output logic [16:0] DinI,
  input  logic        push_out,
  output logic [2:0]  inflight,
  output logic        busy,
  output logic        err_underflow
`ifdef FFT_SEQ_STATS_EN
  ,
  output logic [15:0] frames_fed,
  output logic [15:0] frames_drained
`endif
);

  localparam int SCW    = $clog2(FRAME_LEN);
  localparam int OCW    = (OUT_PER_FRAME > 1) ? $clog2(OUT_PER_FRAME) : 1;
  localparam int STAGES = 1;
  localparam logic [SCW-1:0] S_LAST  = SCW'(FRAME_LEN - 1);
  localparam logic [OCW-1:0] O_LAST  = OCW'(OUT_PER_FRAME - 1);
  localparam logic [2:0]     INF_MAX = 3'(MAX_INFLIGHT);

  typedef enum logic [1:0] {IDLE, RUN, WAIT} state_t;

  state_t         state, state_nxt;
  logic [SCW-1:0] sample_cnt;
  logic [OCW-1:0] out_cnt;
  logic [2:0]     inflight_nxt;
  logic [STAGES:0] vld_pipe;
  logic           accept, frame_done, drain_beat, drain_wrap;

  assign accept       = src_valid && src_ready;
  assign frame_done   = accept && (sample_cnt == S_LAST);
  assign drain_beat   = push_out && (inflight != 3'd0);
  assign drain_wrap   = drain_beat && (out_cnt == O_LAST);
  assign inflight_nxt = inflight + 3'(frame_done) - 3'(drain_wrap);
  assign vld_pipe[0]  = accept;
  assign push_in      = vld_pipe[STAGES];

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // RUN only exits at a frame boundary so a partially fed frame is never abandoned.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (enable) state_nxt = (inflight < INF_MAX) ? RUN : WAIT;
      RUN:  if (frame_done) begin
              if (!enable)                   state_nxt = IDLE;
              else if (inflight_nxt < INF_MAX) state_nxt = RUN;
              else                           state_nxt = WAIT;
            end
      WAIT: if (!enable)                   state_nxt = IDLE;
            else if (inflight < INF_MAX)   state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    src_ready = (state == RUN);
    busy      = (state != IDLE) || (inflight != 3'd0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sample_cnt           <= '0;
      out_cnt              <= '0;
      inflight             <= '0;
      vld_pipe[STAGES:1]   <= '0;
      First_Data           <= 1'b0;
      DinR                 <= '0;
      DinI                 <= '0;
      err_underflow        <= 1'b0;
    end else begin
      vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
      First_Data         <= accept && (sample_cnt == '0);
      inflight           <= inflight_nxt;
      if (accept) begin
        DinR       <= src_re;
        DinI       <= src_im;
        sample_cnt <= frame_done ? '0 : sample_cnt + 1'b1;
      end
      if (drain_beat) out_cnt <= drain_wrap ? '0 : out_cnt + 1'b1;
      if (push_out && (inflight == 3'd0)) err_underflow <= 1'b1;
    end
  end

`ifdef FFT_SEQ_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      frames_fed     <= '0;
      frames_drained <= '0;
    end else begin
      if (frame_done) frames_fed     <= frames_fed + 1'b1;
      if (drain_wrap) frames_drained <= frames_drained + 1'b1;
    end
  end
`endif

endmodule
